scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter SW_WIRE_CNT, default 16, number of switched (drive) wires.
REQ-002 SHALL have parameter RD_WIRE_CNT, default 16, number of read (sense) wires.
REQ-003 SHALL have parameter TSETTLE, default 8, mux settle cycles after each select change; 0 allowed.
REQ-004 SHALL have parameter ADC_W, default 12, ADC sample width.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk_in  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a frame scan.
REQ-009 SHALL have port continuous  input  1  when high at frame end, next frame starts without a new start.
REQ-010 SHALL have port abort  input  1  terminate the scan and return to IDLE.
REQ-011 SHALL have port sw_mux_sel  output  $clog2(SW_WIRE_CNT)  current drive wire index.
REQ-012 SHALL have port rd_mux_sel  output  $clog2(RD_WIRE_CNT)  current sense wire index.
REQ-013 SHALL have port sw_en  output  1  drive enable; high in every state except IDLE.
REQ-014 SHALL have port adc_start  output  1  one-cycle conversion request.
REQ-015 SHALL have port adc_done  input  1  conversion complete, qualifies adc_data.
REQ-016 SHALL have port adc_data  input  ADC_W  conversion result.
REQ-017 SHALL have port out_valid  output  1  sample word valid.
REQ-018 SHALL have port out_ready  input  1  downstream (UART packer) accepts the word.
REQ-019 SHALL have port out_data  output  sel widths+ADC_W  {sw index, rd index, sample}, MSB first.
REQ-020 SHALL have port busy  output  1  high when state is not IDLE.
REQ-021 SHALL have port frame_done  output  1  one-cycle pulse after the last word of a frame is accepted.

Function
REQ-022 FSM states SHALL be IDLE, SELECT, SETTLE, CONVERT, EMIT.
REQ-023 IDLE->SELECT on start; indices SHALL be 0,0 on entry; start is ignored outside IDLE.
REQ-024 SELECT SHALL last 1 cycle with the muxes driven, load the settle counter, then go to SETTLE (or straight to CONVERT if TSETTLE==0).
REQ-025 SETTLE SHALL last exactly TSETTLE cycles.
REQ-026 adc_start SHALL be high only in the first CONVERT cycle; adc_done SHALL be ignored in that cycle and sampled from the following cycle on.
REQ-027 On sampled adc_done, adc_data SHALL be registered into out_data and the FSM SHALL move to EMIT; CONVERT waits indefinitely otherwise.
REQ-028 In EMIT, out_valid SHALL be high and out_data stable until out_valid&&out_ready; no word may be dropped or duplicated.
REQ-029 On handshake: rd index SHALL increment; at RD_WIRE_CNT-1 it SHALL wrap to 0 and the sw index SHALL increment; next state SELECT.
REQ-030 On handshake at sw=SW_WIRE_CNT-1, rd=RD_WIRE_CNT-1: frame_done SHALL pulse the next cycle, indices SHALL return to 0, next state SHALL be SELECT if continuous else IDLE.
REQ-031 Scan order SHALL be rd inner, sw outer: SW_WIRE_CNT*RD_WIRE_CNT words per frame.
REQ-032 abort SHALL take priority over all other transitions: next state IDLE, indices 0, out_valid and adc_start low, no frame_done; a late adc_done in IDLE is ignored.
REQ-033 Minimum cycles per word with zero wait (adc_done one cycle after adc_start, out_ready high) SHALL be 4+TSETTLE.

Reset
REQ-034 On rst_n low, asynchronously: state IDLE, sw_mux_sel=0, rd_mux_sel=0, sw_en=0, adc_start=0, out_valid=0, out_data=0, busy=0, frame_done=0.
REQ-035 Reset mid-frame SHALL discard the in-flight sample; after release the block SHALL wait in IDLE for start.

Verification
REQ-036 SW=2,RD=2,TSETTLE=2, ADC done 3 cycles after start with data 0x100+n, out_ready=1, one start -> 4 words (0,0,0x100),(0,1,0x101),(1,0,0x102),(1,1,0x103), one frame_done, return to IDLE.
REQ-037 Same config, out_ready held low 10 cycles on word 2 -> out_valid and out_data held constant throughout, no adc_start during the stall, sequence intact.
REQ-038 continuous=1 -> after frame_done next word is (0,0) with no start, busy stays high across the frame boundary.
REQ-039 abort asserted during CONVERT of word (1,0) -> IDLE next cycle, no further out_valid, no frame_done; later start scans from (0,0).
REQ-040 rst_n low during SETTLE, then start asserted while busy and TSETTLE=0 -> all outputs at reset values; start ignored when busy; TSETTLE=0 gives 4 cycles SELECT-to-SELECT.

Source files
------------

// File: rtl/scan_ctrl.sv
// Scans an SW x RD wire matrix (rd inner, sw outer), one ADC sample per crossing, 4+TSETTLE cycles per word minimum.
// Each sample is held in out_data until out_valid&&out_ready; the scan stalls in EMIT under backpressure.
module scan_ctrl #(
    parameter int SW_WIRE_CNT = 16,
    parameter int RD_WIRE_CNT = 16,
    parameter int TSETTLE     = 8,
    parameter int ADC_W       = 12,
    localparam int SW_W  = (SW_WIRE_CNT > 1) ? $clog2(SW_WIRE_CNT) : 1,
    localparam int RD_W  = (RD_WIRE_CNT > 1) ? $clog2(RD_WIRE_CNT) : 1,
    localparam int OUT_W = SW_W + RD_W + ADC_W
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    output logic [SW_W-1:0]  sw_mux_sel,
    output logic [RD_W-1:0]  rd_mux_sel,
    output logic             sw_en,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = (TSETTLE > 1) ? $clog2(TSETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = (TSETTLE > 0) ? CNT_W'(TSETTLE - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_CONVERT,
        S_EMIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SW_W-1:0]  sw_idx;
    logic [RD_W-1:0]  rd_idx;
    logic [CNT_W-1:0] settle_cnt;
    logic             conv_first;
    logic             last_sw;
    logic             last_rd;

    assign last_sw    = (sw_idx == SW_W'(SW_WIRE_CNT - 1));
    assign last_rd    = (rd_idx == RD_W'(RD_WIRE_CNT - 1));
    assign sw_mux_sel = sw_idx;
    assign rd_mux_sel = rd_idx;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state_nxt = S_SELECT;
                S_SELECT:  state_nxt = (TSETTLE == 0) ? S_CONVERT : S_SETTLE;
                S_SETTLE:  if (settle_cnt == '0) state_nxt = S_CONVERT;
                // adc_done in the request cycle belongs to nothing we asked for yet
                S_CONVERT: if (!conv_first && adc_done) state_nxt = S_EMIT;
                S_EMIT: begin
                    if (out_ready) begin
                        state_nxt = (last_sw && last_rd && !continuous) ? S_IDLE : S_SELECT;
                    end
                end
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        sw_en     = (state != S_IDLE);
        adc_start = (state == S_CONVERT) && conv_first && !abort;
        out_valid = (state == S_EMIT) && !abort;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sw_idx     <= '0;
            rd_idx     <= '0;
            settle_cnt <= '0;
            conv_first <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            conv_first <= (state != S_CONVERT) && (state_nxt == S_CONVERT);
            if (abort) begin
                sw_idx <= '0;
                rd_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            sw_idx <= '0;
                            rd_idx <= '0;
                        end
                    end
                    S_SELECT: settle_cnt <= SETTLE_LOAD;
                    S_SETTLE: begin
                        if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                    end
                    S_CONVERT: begin
                        if (!conv_first && adc_done) out_data <= {sw_idx, rd_idx, adc_data};
                    end
                    S_EMIT: begin
                        if (out_ready) begin
                            if (last_rd) begin
                                rd_idx <= '0;
                                if (last_sw) begin
                                    sw_idx     <= '0;
                                    frame_done <= 1'b1;
                                end else begin
                                    sw_idx <= sw_idx + 1'b1;
                                end
                            end else begin
                                rd_idx <= rd_idx + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: a 2x2/TSETTLE=2 instance checked every cycle against a scan model, plus a 2x3/TSETTLE=0 instance.
module tb_scan_ctrl;

    localparam int A_SW = 2;
    localparam int A_RD = 2;
    localparam int A_T  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, continuous_a, abort_a, out_ready_a, adc_done_a;
    logic [11:0] adc_data_a;
    logic        sw_sel_a, rd_sel_a, sw_en_a, adc_start_a, out_valid_a, busy_a, frame_done_a;
    logic [13:0] out_data_a;

    logic        start_b, adc_done_b;
    logic        continuous_b = 1'b0;
    logic        abort_b      = 1'b0;
    logic        out_ready_b  = 1'b1;
    logic [7:0]  adc_data_b;
    logic        sw_sel_b, sw_en_b, adc_start_b, out_valid_b, busy_b, frame_done_b;
    logic [1:0]  rd_sel_b;
    logic [10:0] out_data_b;

    int errors = 0;
    int checks = 0;

    scan_ctrl #(.SW_WIRE_CNT(A_SW), .RD_WIRE_CNT(A_RD), .TSETTLE(A_T), .ADC_W(12)) u_dut_a (
        .clk_in(clk), .rst_n(rst_n), .start(start_a), .continuous(continuous_a), .abort(abort_a),
        .sw_mux_sel(sw_sel_a), .rd_mux_sel(rd_sel_a), .sw_en(sw_en_a), .adc_start(adc_start_a),
        .adc_done(adc_done_a), .adc_data(adc_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .busy(busy_a), .frame_done(frame_done_a)
    );

    scan_ctrl #(.SW_WIRE_CNT(2), .RD_WIRE_CNT(3), .TSETTLE(0), .ADC_W(8)) u_dut_b (
        .clk_in(clk), .rst_n(rst_n), .start(start_b), .continuous(continuous_b), .abort(abort_b),
        .sw_mux_sel(sw_sel_b), .rd_mux_sel(rd_sel_b), .sw_en(sw_en_b), .adc_start(adc_start_b),
        .adc_done(adc_done_b), .adc_data(adc_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .busy(busy_b), .frame_done(frame_done_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ADC models: answer each adc_start with done after adc_dly cycles
    int adc_dly = 3;
    int n_a = 0;
    int cd_a = 0;
    initial begin
        adc_done_a = 1'b0;
        adc_data_a = '0;
        forever begin
            @(negedge clk);
            if (adc_start_a) cd_a = adc_dly;
            @(posedge clk);
            #1;
            adc_done_a = 1'b0;
            if (cd_a > 0) begin
                cd_a--;
                if (cd_a == 0) begin
                    adc_done_a = 1'b1;
                    adc_data_a = 12'h100 + 12'(n_a);
                    n_a++;
                end
            end
        end
    end

    int n_b = 0;
    int cd_b = 0;
    initial begin
        adc_done_b = 1'b0;
        adc_data_b = '0;
        forever begin
            @(negedge clk);
            if (adc_start_b) cd_b = 1;
            @(posedge clk);
            #1;
            adc_done_b = 1'b0;
            if (cd_b > 0) begin
                cd_b--;
                if (cd_b == 0) begin
                    adc_done_b = 1'b1;
                    adc_data_b = 8'(n_b);
                    n_b++;
                end
            end
        end
    end

    // Scan model: word k of a frame is (k/RD, k%RD); a word's ADC request comes 2+T cycles after
    // the start or previous handshake; valid follows the first done after the request cycle.
    int   cyc = 0;
    int   k = 0;
    int   due = -1;
    int   fd_cnt = 0;
    int   hs_cnt = 0;
    bit   running = 1'b0;
    bit   pend = 1'b0;
    bit   emit = 1'b0;
    bit   fd_exp = 1'b0;
    logic [11:0] cap = '0;
    logic [13:0] log_dat[$];
    int   log_cyc[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_sw_en", sw_en_a, 0);
                chk("rst_busy", busy_a, 0);
                chk("rst_adc_start", adc_start_a, 0);
                chk("rst_out_valid", out_valid_a, 0);
                chk("rst_out_data", out_data_a, 0);
                chk("rst_sel", {sw_sel_a, rd_sel_a}, 0);
                chk("rst_frame_done", frame_done_a, 0);
                running = 0; k = 0; pend = 0; emit = 0; fd_exp = 0; due = -1;
            end else begin
                chk("busy", busy_a, running);
                chk("sw_en", sw_en_a, running);
                chk("sel", {sw_sel_a, rd_sel_a}, {1'(k / A_RD), 1'(k % A_RD)});
                chk("adc_start", adc_start_a, running && !abort_a && cyc == due);
                chk("out_valid", out_valid_a, emit && !abort_a);
                chk("frame_done", frame_done_a, fd_exp);
                if (out_valid_a) chk("out_data", out_data_a, {1'(k / A_RD), 1'(k % A_RD), cap});
                if (frame_done_a) fd_cnt++;
                fd_exp = 0;
                if (abort_a) begin
                    running = 0; k = 0; pend = 0; emit = 0;
                end else if (running) begin
                    if (cyc == due) begin
                        pend = 1;
                    end else if (pend && adc_done_a) begin
                        pend = 0; emit = 1; cap = adc_data_a;
                    end else if (emit && out_ready_a) begin
                        log_dat.push_back(out_data_a);
                        log_cyc.push_back(cyc);
                        hs_cnt++;
                        emit = 0;
                        k++;
                        due = cyc + 2 + A_T;
                        if (k == A_SW * A_RD) begin
                            k = 0; fd_exp = 1; running = continuous_a;
                        end
                    end
                end else if (start_a) begin
                    running = 1; k = 0; due = cyc + 2 + A_T;
                end
            end
            cyc++;
        end
    end

    task automatic wait_fd(input string nm);
        int f0;
        int i;
        f0 = fd_cnt;
        i = 0;
        while (fd_cnt == f0 && i < 400) begin tick(); i++; end
        chk(nm, fd_cnt != f0, 1);
    endtask

    task automatic wait_hs(input int target, input string nm);
        int i;
        i = 0;
        while (hs_cnt < target && i < 400) begin tick(); i++; end
        chk(nm, hs_cnt >= target, 1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        int h0, h1, f0, n0, nv, na, nfd, last, i;
        logic [13:0] held, w;
        logic [10:0] lastw;

        rst_n = 1'b0; start_a = 0; continuous_a = 0; abort_a = 0; out_ready_a = 1; start_b = 0;
        repeat (3) tick();
        chk("reset_busy", busy_a, 0);
        chk("reset_out_data", out_data_a, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single frame, done 3 cycles after request
        adc_dly = 3;
        h0 = hs_cnt;
        pulse_start_a();
        wait_fd("p1_frame_timeout");
        chk("p1_words", hs_cnt - h0, 4);
        chk("p1_w0", log_dat[h0], 14'h0100);
        chk("p1_w1", log_dat[h0+1], 14'h1101);
        chk("p1_w2", log_dat[h0+2], 14'h2102);
        chk("p1_w3", log_dat[h0+3], 14'h3103);
        chk("p1_spacing", log_cyc[h0+1] - log_cyc[h0], 8);
        repeat (3) tick();
        chk("p1_idle", busy_a, 0);
        chk("p1_one_frame_done", fd_cnt, 1);

        // Zero-wait throughput
        adc_dly = 1;
        h0 = hs_cnt;
        pulse_start_a();
        wait_fd("p1b_frame_timeout");
        for (int j = 1; j < 4; j++) chk("p1b_spacing", log_cyc[h0+j] - log_cyc[h0+j-1], 6);

        // Ten-cycle stall on the third word
        adc_dly = 3;
        h0 = hs_cnt;
        n0 = n_a;
        pulse_start_a();
        wait_hs(h0 + 2, "p2_two_words_timeout");
        out_ready_a = 1'b0;
        i = 0;
        while (!out_valid_a && i < 100) begin tick(); i++; end
        chk("p2_valid_seen", out_valid_a, 1);
        held = out_data_a;
        repeat (10) begin
            tick();
            chk("p2_hold_valid", out_valid_a, 1);
            chk("p2_hold_data", out_data_a, held);
            chk("p2_no_adc_start", adc_start_a, 0);
        end
        out_ready_a = 1'b1;
        wait_fd("p2_frame_timeout");
        chk("p2_words", hs_cnt - h0, 4);
        for (int j = 0; j < 4; j++)
            chk("p2_seq", log_dat[h0+j], {1'(j / 2), 1'(j % 2), 12'h100 + 12'(n0 + j)});

        // Continuous: next frame starts by itself
        continuous_a = 1'b1;
        pulse_start_a();
        wait_fd("p3_frame1_timeout");
        h1 = hs_cnt;
        i = 0;
        while (hs_cnt == h1 && i < 50) begin
            chk("p3_busy_across", busy_a, 1);
            tick();
            i++;
        end
        chk("p3_next_word_seen", hs_cnt > h1, 1);
        w = log_dat[h1];
        chk("p3_first_word_sel", w[13:12], 0);
        continuous_a = 1'b0;
        wait_fd("p3_frame2_timeout");
        repeat (2) tick();
        chk("p3_idle", busy_a, 0);

        // Abort during conversion of (1,0)
        adc_dly = 3;
        f0 = fd_cnt;
        pulse_start_a();
        i = 0;
        while (!(adc_start_a && sw_sel_a && !rd_sel_a) && i < 100) begin tick(); i++; end
        chk("p4_reached_1_0", adc_start_a && sw_sel_a && !rd_sel_a, 1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("p4_idle", busy_a, 0);
        nv = 0;
        repeat (20) begin
            tick();
            if (out_valid_a || frame_done_a) nv++;
        end
        chk("p4_quiet", nv, 0);
        chk("p4_no_frame_done", fd_cnt - f0, 0);
        h0 = hs_cnt;
        pulse_start_a();
        wait_hs(h0 + 1, "p4_restart_timeout");
        w = log_dat[h0];
        chk("p4_restart_sel", w[13:12], 0);
        wait_fd("p4_frame_timeout");

        // Random traffic
        h0 = hs_cnt;
        repeat (3000) begin
            adc_dly      = $urandom_range(1, 4);
            out_ready_a  = ($urandom_range(0, 3) != 0);
            continuous_a = ($urandom_range(0, 7) == 0);
            start_a      = ($urandom_range(0, 9) == 0);
            abort_a      = ($urandom_range(0, 149) == 0);
            tick();
        end
        start_a = 0; abort_a = 0; continuous_a = 0; out_ready_a = 1;
        i = 0;
        while (busy_a && i < 500) begin tick(); i++; end
        chk("p5_drain", busy_a, 0);
        chk("p5_activity", hs_cnt > h0 + 50, 1);

        // Reset during SETTLE
        adc_dly = 1;
        pulse_start_a();
        tick();
        rst_n = 1'b0;
        #1;
        chk("p6_busy", busy_a, 0);
        chk("p6_sw_en", sw_en_a, 0);
        chk("p6_out_data", out_data_a, 0);
        chk("p6_sel", {sw_sel_a, rd_sel_a}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("p6_waits_idle", busy_a, 0);

        // TSETTLE=0 instance: 4 cycles per word, start ignored while busy
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        na = 0; nv = 0; nfd = 0; last = -1; lastw = '0;
        for (int j = 0; j < 200 && nfd == 0; j++) begin
            if (adc_start_b) begin
                if (last >= 0) chk("b_spacing", j - last, 4);
                last = j;
                na++;
            end
            if (out_valid_b) begin nv++; lastw = out_data_b; end
            if (frame_done_b) nfd++;
            start_b = (j == 7);
            tick();
        end
        start_b = 1'b0;
        chk("b_conversions", na, 6);
        chk("b_words", nv, 6);
        chk("b_frame_done", nfd, 1);
        chk("b_last_word", lastw, 11'h605);
        repeat (2) tick();
        chk("b_idle", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
